// File: rtl/map_reg_write_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write-only register slave between two requesters.
// Optional watchdog abort is compiled in with `define AXIW_ARB_TIMEOUT_EN.
module map_reg_write_arbiter #(
   parameter int unsigned ADDRESS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [ADDRESS_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0]    req0_data,
   output logic                     rsp0_valid,
   output logic [1:0]               rsp0_resp,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [ADDRESS_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0]    req1_data,
   output logic                     rsp1_valid,
   output logic [1:0]               rsp1_resp,

   output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DATA_WIDTH-1:0]    m_axi_wdata,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,

   output logic                     busy,
   output logic                     grant,
   output logic                     timeout
);

   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("map_reg_write_arbiter: TIMEOUT_CYCLES must be within 2..65535");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_RSP
   } state_t;

   state_t                     state_q;
   state_t                     state_d;
   logic                       last_grant_q;
   logic                       last_grant_d;
   logic                       grant_d;
   logic                       busy_d;
   logic [ADDRESS_WIDTH-1:0]   awaddr_d;
   logic [DATA_WIDTH-1:0]      wdata_d;
   logic                       awvalid_d;
   logic                       wvalid_d;
   logic                       bready_d;
   logic                       rsp0_valid_d;
   logic                       rsp1_valid_d;
   logic [1:0]                 rsp0_resp_d;
   logic [1:0]                 rsp1_resp_d;
   logic                       rsp_fire;
   logic [1:0]                 rsp_code;
   logic                       any_req;
   logic                       pick;
   logic                       wd_hit;

   // Contention goes to whoever was not served last; otherwise the sole requester wins.
   assign any_req = req0_valid | req1_valid;
   assign pick    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

`ifdef AXIW_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

   logic [15:0] wd_cnt_q;
   logic        in_txn;

   assign in_txn = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B);
   // A B handshake landing on the limit cycle still completes normally.
   assign wd_hit = in_txn && (wd_cnt_q == WD_LIMIT) &&
                   !((state_q == ST_B) && m_axi_bvalid);

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= wd_hit;
         if (state_q == ST_IDLE) begin
            wd_cnt_q <= '0;
         end else if (in_txn) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
         end
      end
   end
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Next-state, next registered outputs and the combinational accept pulse.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant;
      awaddr_d     = m_axi_awaddr;
      wdata_d      = m_axi_wdata;
      awvalid_d    = m_axi_awvalid;
      wvalid_d     = m_axi_wvalid;
      bready_d     = m_axi_bready;
      rsp_fire     = 1'b0;
      rsp_code     = 2'b00;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rsp0_resp_d  = 2'b00;
      rsp1_resp_d  = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (any_req && !rst) begin
               grant_d    = pick;
               req0_ready = ~pick;
               req1_ready = pick;
               awaddr_d   = pick ? req1_addr : req0_addr;
               wdata_d    = pick ? req1_data : req0_data;
               awvalid_d  = 1'b1;
               state_d    = ST_AW;
            end
         end
         ST_AW: begin
            if (m_axi_awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               state_d   = ST_W;
            end
         end
         ST_W: begin
            if (m_axi_wready) begin
               wvalid_d = 1'b0;
               bready_d = 1'b1;
               state_d  = ST_B;
            end
         end
         ST_B: begin
            if (m_axi_bvalid) begin
               bready_d = 1'b0;
               rsp_fire = 1'b1;
               rsp_code = m_axi_bresp;
               state_d  = ST_RSP;
            end
         end
         ST_RSP: begin
            last_grant_d = grant;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Watchdog abort overrides whatever phase was in flight.
      if (wd_hit) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         rsp_fire  = 1'b1;
         rsp_code  = RESP_SLVERR;
         state_d   = ST_RSP;
      end

      if (rsp_fire) begin
         if (grant) begin
            rsp1_valid_d = 1'b1;
            rsp1_resp_d  = rsp_code;
         end else begin
            rsp0_valid_d = 1'b1;
            rsp0_resp_d  = rsp_code;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         grant         <= 1'b0;
         busy          <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         rsp0_valid    <= 1'b0;
         rsp1_valid    <= 1'b0;
         rsp0_resp     <= 2'b00;
         rsp1_resp     <= 2'b00;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant         <= grant_d;
         busy          <= busy_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_wdata   <= wdata_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
         rsp0_valid    <= rsp0_valid_d;
         rsp1_valid    <= rsp1_valid_d;
         rsp0_resp     <= rsp0_resp_d;
         rsp1_resp     <= rsp1_resp_d;
      end
   end

endmodule

// File: tb/tb_map_reg_write_arbiter.sv
// Directed bench for map_reg_write_arbiter with a small AXI4-Lite register slave model.
module tb_map_reg_write_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic          rsp0_valid, rsp1_valid;
   logic [1:0]    rsp0_resp, rsp1_resp;
   logic [AW-1:0] m_axi_awaddr;
   logic          m_axi_awvalid, m_axi_awready;
   logic [DW-1:0] m_axi_wdata;
   logic          m_axi_wvalid, m_axi_wready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid, m_axi_bready;
   logic          busy, grant, timeout;

   int total;
   int bad;

   // Slave model controls and state
   int unsigned   aw_stall;
   logic          b_en;
   int unsigned   aw_cnt;
   logic [AW-1:0] slv_addr;
   logic          b_pending;
   logic [DW-1:0] output_reg;
   int unsigned   aw_beats;
   int unsigned   w_beats;

   map_reg_write_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_addr    (req0_addr),
      .req0_data    (req0_data),
      .rsp0_valid   (rsp0_valid),
      .rsp0_resp    (rsp0_resp),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_addr    (req1_addr),
      .req1_data    (req1_data),
      .rsp1_valid   (rsp1_valid),
      .rsp1_resp    (rsp1_resp),
      .m_axi_awaddr (m_axi_awaddr),
      .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata  (m_axi_wdata),
      .m_axi_wvalid (m_axi_wvalid),
      .m_axi_wready (m_axi_wready),
      .m_axi_bresp  (m_axi_bresp),
      .m_axi_bvalid (m_axi_bvalid),
      .m_axi_bready (m_axi_bready),
      .busy         (busy),
      .grant        (grant),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Register at address 0 accepts writes with OKAY; any other address returns SLVERR.
   assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_stall);
   assign m_axi_wready  = m_axi_wvalid;
   assign m_axi_bvalid  = b_pending && b_en;
   assign m_axi_bresp   = (slv_addr == '0) ? 2'b00 : 2'b10;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_cnt     <= 0;
         slv_addr   <= '0;
         b_pending  <= 1'b0;
         output_reg <= '0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            slv_addr  <= m_axi_awaddr;
            aw_cnt    <= 0;
            b_pending <= 1'b0;
            aw_beats  <= aw_beats + 1;
         end else if (m_axi_awvalid) begin
            aw_cnt <= aw_cnt + 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            b_pending <= 1'b1;
            w_beats   <= w_beats + 1;
            if (slv_addr == '0) output_reg <= m_axi_wdata;
         end
         if (m_axi_bvalid && m_axi_bready) b_pending <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One zero-wait transaction; entered at a negedge with the DUT idle.
   task automatic txn(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [1:0] exp_resp);
      if (sel) begin
         req1_valid = 1'b1; req1_addr = addr; req1_data = data;
      end else begin
         req0_valid = 1'b1; req0_addr = addr; req0_data = data;
      end
      #1;
      chk("ready_sel",   64'(sel ? req1_ready : req0_ready), 64'd1);
      chk("ready_other", 64'(sel ? req0_ready : req1_ready), 64'd0);
      @(negedge clk);
      if (sel) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk("aw_valid", 64'(m_axi_awvalid), 64'd1);
      chk("aw_addr",  64'(m_axi_awaddr), 64'(addr));
      chk("aw_no_w",  64'(m_axi_wvalid), 64'd0);
      chk("grant",    64'(grant), 64'(sel));
      chk("busy_aw",  64'(busy), 64'd1);
      @(negedge clk);
      chk("w_valid",  64'(m_axi_wvalid), 64'd1);
      chk("w_data",   64'(m_axi_wdata), 64'(data));
      chk("w_no_aw",  64'(m_axi_awvalid), 64'd0);
      @(negedge clk);
      chk("b_ready",  64'(m_axi_bready), 64'd1);
      chk("b_no_w",   64'(m_axi_wvalid), 64'd0);
      @(negedge clk);
      chk("rsp_valid", 64'(sel ? rsp1_valid : rsp0_valid), 64'd1);
      chk("rsp_resp",  64'(sel ? rsp1_resp : rsp0_resp), 64'(exp_resp));
      chk("rsp_other", 64'(sel ? rsp0_valid : rsp1_valid), 64'd0);
      chk("rsp_no_b",  64'(m_axi_bready), 64'd0);
      @(negedge clk);
      chk("rsp_done",  64'(sel ? rsp1_valid : rsp0_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int unsigned aw0;
      int unsigned w0;
      int          hit;
      clk = 1'b0; rst = 1'b1;
      total = 0; bad = 0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      aw_stall = 0; b_en = 1'b1; aw_beats = 0; w_beats = 0;

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
      chk("rst_wvalid",  64'(m_axi_wvalid), 64'd0);
      chk("rst_bready",  64'(m_axi_bready), 64'd0);
      chk("rst_busy",    64'(busy), 64'd0);
      chk("rst_grant",   64'(grant), 64'd0);
      chk("rst_rsp",     64'({rsp0_valid, rsp1_valid, rsp0_resp, rsp1_resp}), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single req0 write to the register
      aw0 = aw_beats; w0 = w_beats;
      txn(1'b0, 32'h0, 32'd100, 2'b00);
      chk("aw_beats_1", 64'(aw_beats - aw0), 64'd1);
      chk("w_beats_1",  64'(w_beats - w0), 64'd1);
      chk("out_reg_100", 64'(output_reg), 64'd100);

      // req1 to an unmapped address
      txn(1'b1, 32'h4, 32'd500, 2'b10);
      chk("out_reg_kept", 64'(output_reg), 64'd100);

      // Contention after reset: req0 first, then req1
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      req1_valid = 1'b1; req1_addr = 32'h0; req1_data = 32'd750;
      txn(1'b0, 32'h0, 32'd250, 2'b00);
      chk("out_reg_250", 64'(output_reg), 64'd250);
      txn(1'b1, 32'h0, 32'd750, 2'b00);
      chk("out_reg_750", 64'(output_reg), 64'd750);
      req1_valid = 1'b1; req1_addr = 32'h0; req1_data = 32'd31;
      txn(1'b0, 32'h0, 32'd30, 2'b00);
      txn(1'b1, 32'h0, 32'd31, 2'b00);

      // AW held off for 3 cycles
      aw_stall = 3;
      req0_valid = 1'b1; req0_addr = 32'h0; req0_data = 32'd42;
      #1;
      chk("stall_ready", 64'(req0_ready), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         req0_valid = 1'b0;
         chk("stall_awvalid", 64'(m_axi_awvalid), 64'd1);
         chk("stall_awaddr",  64'(m_axi_awaddr), 64'd0);
         chk("stall_no_w",    64'(m_axi_wvalid), 64'd0);
      end
      @(negedge clk);
      chk("stall_w",     64'(m_axi_wvalid), 64'd1);
      chk("stall_aw_lo", 64'(m_axi_awvalid), 64'd0);
      @(negedge clk);
      chk("stall_b", 64'(m_axi_bready), 64'd1);
      @(negedge clk);
      chk("stall_rsp", 64'({rsp0_valid, rsp0_resp}), 64'b100);
      @(negedge clk);
      chk("stall_idle", 64'(busy), 64'd0);
      chk("out_reg_42", 64'(output_reg), 64'd42);
      aw_stall = 0;

`ifdef AXIW_ARB_TIMEOUT_EN
      // Watchdog abort when B never arrives
      b_en = 1'b0;
      req0_valid = 1'b1; req0_addr = 32'h0; req0_data = 32'd5;
      hit = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         req0_valid = 1'b0;
         if (rsp0_valid) begin
            hit = c;
            break;
         end
      end
      chk("to_cycle",   64'(hit), 64'd17);
      chk("to_resp",    64'(rsp0_resp), 64'd2);
      chk("to_pulse",   64'(timeout), 64'd1);
      chk("to_bready",  64'(m_axi_bready), 64'd0);
      @(negedge clk);
      chk("to_clear", 64'({timeout, busy}), 64'd0);
      b_en = 1'b1;
      txn(1'b0, 32'h0, 32'd6, 2'b00);
      chk("out_reg_6", 64'(output_reg), 64'd6);
`else
      hit = 0;
`endif

      // Reset while waiting in B; last served was req0, so only reset restores req0 priority
      b_en = 1'b0;
      req0_valid = 1'b1; req0_addr = 32'h0; req0_data = 32'd77;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rb_in_b", 64'(m_axi_bready), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rb_axi",   64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
      chk("rb_wdata", 64'(m_axi_wdata), 64'd0);
      chk("rb_state", 64'({busy, grant, timeout, req0_ready, req1_ready}), 64'd0);
      chk("rb_rsp",   64'({rsp0_valid, rsp1_valid, rsp0_resp, rsp1_resp}), 64'd0);
      rst = 1'b0; b_en = 1'b1;
      @(negedge clk);
      chk("rb_no_rsp", 64'({rsp0_valid, busy}), 64'd0);
      req1_valid = 1'b1; req1_addr = 32'h0; req1_data = 32'd22;
      txn(1'b0, 32'h0, 32'd11, 2'b00);
      txn(1'b1, 32'h0, 32'd22, 2'b00);
      chk("out_reg_22", 64'(output_reg), 64'd22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
